univ_shift_reg: RTL and testbench

//  Parametrised universal shift register, next generation of the catalog's serial shifter.

---
 rtl/univ_shift_pkg.sv | 33 +++
 rtl/univ_shift_reg_shift_step.sv | 29 ++
 rtl/univ_shift_reg.sv | 137 +++++++++++++
 tb/tb_univ_shift_reg.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/univ_shift_pkg.sv
// Shared types for the universal shift register.
//   op_e      : 3-bit command opcode
//   state_e   : controller states
//   amt_w()   : width of a shift-amount field able to hold 0..width
package univ_shift_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_SRL  = 3'b010,
    OP_SLL  = 3'b011,
    OP_SRA  = 3'b100,
    OP_ROR  = 3'b101,
    OP_ROL  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int amt_w(input int width);
    return $clog2(width) + 1;
  endfunction

  // True for the ops that run multi-cycle through the SHIFT state.
  function automatic logic is_shift_op(input op_e op);
    return (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA) ||
           (op == OP_ROR) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/univ_shift_reg_shift_step.sv
// One single-bit step of a shift/rotate, purely combinational.
//   op     : opcode; non-shift ops pass q_in through unchanged
//   sin    : serial fill bit for SRL/SLL
//   q_in   : current register value
//   q_out  : register value after one step
module shift_step
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op,
  input  logic             sin,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] q_out
);

  always_comb begin
    q_out = q_in;
    case (op)
      OP_SRL:  q_out = {sin, q_in[WIDTH-1:1]};
      OP_SLL:  q_out = {q_in[WIDTH-2:0], sin};
      OP_SRA:  q_out = {q_in[WIDTH-1], q_in[WIDTH-1:1]};
      OP_ROR:  q_out = {q_in[0], q_in[WIDTH-1:1]};
      OP_ROL:  q_out = {q_in[WIDTH-2:0], q_in[WIDTH-1]};
      default: q_out = q_in;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, logical/arithmetic shifts and
// rotates, one bit per enabled clock, under a valid/ready command handshake.
//
// Optional feature macro: UNIV_SHIFT_ABORT_EN adds the abort input, which
// drops an in-progress shift back to IDLE without a done pulse.
//
// Ports
//   clk, rst    : clock; synchronous active-low reset
//   abort       : (UNIV_SHIFT_ABORT_EN only) cancel the running shift
//   en          : step enable while shifting
//   cmd_valid/cmd_ready/cmd_op/cmd_amt : command handshake and fields
//   d_par       : parallel load data
//   sin         : serial input, sampled live on every step
//   q           : register contents
//   sout_msb/sout_lsb : q[WIDTH-1] / q[0]
//   busy        : shift in progress
//   done        : one-cycle pulse once q holds the last command's result
//
// state | meaning
// IDLE  | ready for a command; LOAD/NOP/zero-amount complete here
// SHIFT | stepping one bit per enabled edge until cnt reaches zero
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = amt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef UNIV_SHIFT_ABORT_EN
  input  logic             abort,
`endif
  input  logic             en,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] d_par,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_q;
  op_e              cmd_op_e;

  assign cmd_op_e = op_e'(cmd_op);

  // The step always uses the live sin, so only the opcode is captured.
  shift_step #(.WIDTH(WIDTH)) u_step (
    .op    (op_q),
    .sin   (sin),
    .q_in  (q_q),
    .q_out (step_q)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // en is deliberately ignored on accept.
        if (cmd_valid) begin
          if (cmd_op_e == OP_LOAD) begin
            q_d    = d_par;
            done_d = 1'b1;
          end else if (is_shift_op(cmd_op_e) && (cmd_amt != '0)) begin
            op_d    = cmd_op_e;
            cnt_d   = cmd_amt;
            state_d = SHIFT;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      SHIFT: begin
`ifdef UNIV_SHIFT_ABORT_EN
        if (abort) begin
          // Partially shifted value is kept on purpose.
          cnt_d   = '0;
          state_d = IDLE;
        end else
`endif
        if (en) begin
          q_d   = step_q;
          cnt_d = cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == SHIFT);
  assign done      = done_q;
  assign q         = q_q;
  assign sout_msb  = q_q[WIDTH-1];
  assign sout_lsb  = q_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

  localparam int W = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_amt;
  logic [W-1:0]  d_par;
  logic          sin;
  logic [W-1:0]  q;
  logic          sout_msb;
  logic          sout_lsb;
  logic          busy;
  logic          done;
`ifdef UNIV_SHIFT_ABORT_EN
  logic          abort;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] mq;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef UNIV_SHIFT_ABORT_EN
    .abort     (abort),
`endif
    .en        (en),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_amt   (cmd_amt),
    .d_par     (d_par),
    .sin       (sin),
    .q         (q),
    .sout_msb  (sout_msb),
    .sout_lsb  (sout_lsb),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-command result computed in closed form from the op rules,
  // assuming sin is constant for the duration of the command.
  function automatic logic [W-1:0] model(input logic [2:0] op, input int amt,
                                         input logic [W-1:0] qv, input logic [W-1:0] dp,
                                         input logic s);
    int n, k, r, sv;
    n = (amt > W) ? W : amt;
    k = amt % W;
    r = qv;
    case (op)
      3'd1: r = dp;
      3'd2: r = (qv >> n) | (s ? ((32'hFF << (W - n)) & 32'hFF) : 0);
      3'd3: r = ((qv << n) & 32'hFF) | (s ? ((1 << n) - 1) : 0);
      3'd4: begin
        sv = qv[W-1] ? int'(qv) - 256 : int'(qv);
        r  = sv >>> n;
      end
      3'd5: r = (k == 0) ? qv : ((qv >> k) | (qv << (W - k)));
      3'd6: r = (k == 0) ? qv : ((qv << k) | (qv >> (W - k)));
      default: r = qv;
    endcase
    return W'(r & 32'hFF);
  endfunction

  // en_mode: 0 = always on, 1 = random, 2 = alternating starting low
  task automatic run_cmd(input string tag, input logic [2:0] op, input int amt,
                         input logic [W-1:0] dp, input logic s, input int en_mode);
    int n_en, exp_en, cyc;
    logic e, got_done;
    logic [W-1:0] exp_q, q_prev;
    exp_q  = model(op, amt, mq, dp, s);
    exp_en = (op >= 3'd2 && op <= 3'd6 && amt > 0) ? amt : 0;
    chk({tag, "_ready"}, 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_amt = AW'(amt); d_par = dp; sin = s;
    en = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n_en = 0; cyc = 0; got_done = done;
    while (!got_done && cyc < 200) begin
      chk({tag, "_busy"}, 32'(busy), 1);
      if (en_mode == 0)      e = 1'b1;
      else if (en_mode == 2) e = (cyc % 2 == 1);
      else                   e = 1'($urandom_range(0, 1));
      en = e;
      if ($urandom_range(0, 3) == 0) begin
        cmd_valid = 1'b1; cmd_op = 3'd1; d_par = W'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      q_prev = q;
      @(posedge clk); #1;
      if (e) n_en++;
      else chk({tag, "_hold"}, 32'(q), 32'(q_prev));
      cyc++;
      got_done = done;
    end
    cmd_valid = 1'b0;
    chk({tag, "_done"}, 32'(got_done), 1);
    chk({tag, "_steps"}, n_en, exp_en);
    chk({tag, "_q"}, 32'(q), 32'(exp_q));
    chk({tag, "_sout"}, {sout_msb, sout_lsb}, {exp_q[W-1], exp_q[0]});
    chk({tag, "_idle"}, 32'(busy), 0);
    mq = exp_q;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; cmd_valid = 1'b1; cmd_op = 3'd1; cmd_amt = 4'd3;
    d_par = 8'h5A; sin = 1'b1;
`ifdef UNIV_SHIFT_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", 32'(q), 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_done", 32'(done), 0);
    mq = '0;

    run_cmd("load_a5", 3'd1, 0, 8'hA5, 1'b0, 0);
    run_cmd("sra3", 3'd4, 3, 8'h00, 1'b0, 0);
    chk("sra3_f4", 32'(q), 32'h F4);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 0);

    run_cmd("load_81", 3'd1, 0, 8'h81, 1'b0, 0);
    run_cmd("rol9", 3'd6, 9, 8'h00, 1'b0, 0);
    chk("rol9_03", 32'(q), 32'h03);
    run_cmd("load_81b", 3'd1, 0, 8'h81, 1'b0, 0);
    run_cmd("ror1_en", 3'd5, 1, 8'h00, 1'b0, 2);
    chk("ror1_c0", 32'(q), 32'hC0);

    run_cmd("load_00", 3'd1, 0, 8'h00, 1'b0, 0);
    run_cmd("sll8", 3'd3, 8, 8'h00, 1'b1, 1);
    chk("sll8_ff", 32'(q), 32'hFF);
    run_cmd("srl0", 3'd2, 0, 8'h00, 1'b0, 0);
    chk("srl0_ff", 32'(q), 32'hFF);
    run_cmd("rsvd", 3'd7, 5, 8'h11, 1'b0, 0);
    run_cmd("nop", 3'd0, 5, 8'h22, 1'b1, 0);

    // Reset in the middle of a shift aborts without a done pulse.
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_amt = 4'd8; sin = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("mid_rst_q", 32'(q), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(cmd_ready), 1);
    chk("mid_rst_done", 32'(done), 0);
    @(posedge clk); #1;
    chk("mid_rst_done2", 32'(done), 0);
    mq = '0;

`ifdef UNIV_SHIFT_ABORT_EN
    run_cmd("load_f0", 3'd1, 0, 8'hF0, 1'b0, 0);
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_amt = 4'd4; sin = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_q", 32'(q), 32'h3C);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ready", 32'(cmd_ready), 1);
    chk("abort_done", 32'(done), 0);
    @(posedge clk); #1;
    chk("abort_done2", 32'(done), 0);
    mq = 8'h3C;
`endif

    // Random commands issued back-to-back in each done cycle.
    for (int i = 0; i < 150; i++) begin
      run_cmd("rnd", 3'($urandom_range(0, 7)), int'($urandom_range(0, 11)),
              W'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
